// File: rtl/hsiao_ecc_pkg.sv
// Shared constants, error encodings and H-matrix column generator for the Hsiao SEC-DED codec.
package hsiao_ecc_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int PROT_WIDTH = 7;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_CORR   = 2'b01;
    localparam logic [1:0] ERR_UNCORR = 2'b10;

    // Data column idx: idx-th odd-weight (>=3) value of pw bits, lower weights first,
    // ascending numeric order within a weight class.
    function automatic logic [31:0] hsiao_col(input int idx, input int pw);
        int          n;
        logic [31:0] res;
        n   = 0;
        res = '0;
        for (int w = 3; w <= pw; w += 2) begin
            for (int v = 0; v < (1 << pw); v++) begin
                if ($countones(v) == w) begin
                    if (n == idx) res = v;
                    n++;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hsiao_ecc_parity_gen.sv
// Combinational check-bit generator: check[j] = XOR of data bits whose H column has bit j set.
module hsiao_ecc_parity_gen
    import hsiao_ecc_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH,
    parameter int ProtWidth = PROT_WIDTH
) (
    input  logic [DataWidth-1:0] data_i,
    output logic [ProtWidth-1:0] check_o
);

    logic [DataWidth-1:0][ProtWidth-1:0] cols;

    for (genvar i = 0; i < DataWidth; i++) begin : g_col
        localparam logic [31:0] COL = hsiao_col(i, ProtWidth);
        assign cols[i] = COL[ProtWidth-1:0];
    end

    always_comb begin
        check_o = '0;
        for (int i = 0; i < DataWidth; i++) begin
            for (int j = 0; j < ProtWidth; j++) begin
                if (cols[i][j]) check_o[j] = check_o[j] ^ data_i[i];
            end
        end
    end

endmodule

// File: rtl/hsiao_ecc_codec.sv
// Hsiao SEC-DED encode/decode channels, each a single-entry elastic register.
// Optional error counters enabled by defining HSIAO_ECC_CNT_EN.
module hsiao_ecc_codec
    import hsiao_ecc_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH,
    parameter int ProtWidth = PROT_WIDTH
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           enc_valid_i,
    output logic                           enc_ready_o,
    input  logic [DataWidth-1:0]           enc_data_i,
    output logic                           enc_valid_o,
    input  logic                           enc_ready_i,
    output logic [DataWidth+ProtWidth-1:0] enc_cw_o,
    input  logic                           dec_valid_i,
    output logic                           dec_ready_o,
    input  logic [DataWidth+ProtWidth-1:0] dec_cw_i,
    output logic                           dec_valid_o,
    input  logic                           dec_ready_i,
    output logic [DataWidth-1:0]           dec_data_o,
    output logic [ProtWidth-1:0]           dec_syndrome_o,
    output logic [1:0]                     dec_err_o
`ifdef HSIAO_ECC_CNT_EN
    ,
    output logic [15:0]                    cnt_corr_o,
    output logic [15:0]                    cnt_uncorr_o
`endif
);

    localparam int CW = DataWidth + ProtWidth;

    logic [DataWidth-1:0][ProtWidth-1:0] cols;

    for (genvar i = 0; i < DataWidth; i++) begin : g_col
        localparam logic [31:0] COL = hsiao_col(i, ProtWidth);
        assign cols[i] = COL[ProtWidth-1:0];
    end

    // Encode channel
    logic [ProtWidth-1:0] enc_check;
    logic                 enc_valid_q;
    logic [CW-1:0]        enc_cw_q;

    hsiao_ecc_parity_gen #(.DataWidth(DataWidth), .ProtWidth(ProtWidth)) u_enc_par (
        .data_i  (enc_data_i),
        .check_o (enc_check)
    );

    assign enc_ready_o = ~enc_valid_q | enc_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enc_valid_q <= 1'b0;
            enc_cw_q    <= '0;
        end else if (enc_ready_o) begin
            enc_valid_q <= enc_valid_i;
            if (enc_valid_i) enc_cw_q <= {enc_check, enc_data_i};
        end
    end

    assign enc_valid_o = enc_valid_q;
    assign enc_cw_o    = enc_cw_q;

    // Decode channel
    logic [DataWidth-1:0] rx_data;
    logic [ProtWidth-1:0] rx_check, dec_par, syn_d;
    logic [DataWidth-1:0] data_d;
    logic [1:0]           err_d;
    logic                 hit;

    assign rx_data  = dec_cw_i[DataWidth-1:0];
    assign rx_check = dec_cw_i[CW-1:DataWidth];

    hsiao_ecc_parity_gen #(.DataWidth(DataWidth), .ProtWidth(ProtWidth)) u_dec_par (
        .data_i  (rx_data),
        .check_o (dec_par)
    );

    assign syn_d = rx_check ^ dec_par;

    // Only odd-weight syndromes can name a single flipped bit; check-bit hits leave data alone.
    always_comb begin
        data_d = rx_data;
        err_d  = ERR_NONE;
        hit    = 1'b0;
        if (syn_d != '0) begin
            if (^syn_d) begin
                for (int i = 0; i < DataWidth; i++) begin
                    if (syn_d == cols[i]) begin
                        data_d[i] = ~rx_data[i];
                        hit       = 1'b1;
                    end
                end
                if ($onehot(syn_d)) hit = 1'b1;
            end
            err_d = hit ? ERR_CORR : ERR_UNCORR;
        end
    end

    logic                 dec_valid_q;
    logic [DataWidth-1:0] dec_data_q;
    logic [ProtWidth-1:0] dec_syn_q;
    logic [1:0]           dec_err_q;

    assign dec_ready_o = ~dec_valid_q | dec_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dec_valid_q <= 1'b0;
            dec_data_q  <= '0;
            dec_syn_q   <= '0;
            dec_err_q   <= ERR_NONE;
        end else if (dec_ready_o) begin
            dec_valid_q <= dec_valid_i;
            if (dec_valid_i) begin
                dec_data_q <= data_d;
                dec_syn_q  <= syn_d;
                dec_err_q  <= err_d;
            end
        end
    end

    assign dec_valid_o    = dec_valid_q;
    assign dec_data_o     = dec_data_q;
    assign dec_syndrome_o = dec_syn_q;
    assign dec_err_o      = dec_err_q;

`ifdef HSIAO_ECC_CNT_EN
    logic        dec_push;
    logic [15:0] cnt_corr_q, cnt_uncorr_q;

    assign dec_push = dec_valid_i & dec_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
        end else if (dec_push) begin
            if (err_d == ERR_CORR && cnt_corr_q != 16'hFFFF)
                cnt_corr_q <= cnt_corr_q + 16'd1;
            if (err_d == ERR_UNCORR && cnt_uncorr_q != 16'hFFFF)
                cnt_uncorr_q <= cnt_uncorr_q + 16'd1;
        end
    end

    assign cnt_corr_o   = cnt_corr_q;
    assign cnt_uncorr_o = cnt_uncorr_q;
`endif

endmodule

// File: tb/tb_hsiao_ecc_codec.sv
// Directed-vector bench for hsiao_ecc_codec; counter checks compile in with HSIAO_ECC_CNT_EN.
module tb_hsiao_ecc_codec;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enc_valid_i, enc_ready_o, enc_valid_o, enc_ready_i;
    logic [31:0] enc_data_i;
    logic [38:0] enc_cw_o;
    logic        dec_valid_i, dec_ready_o, dec_valid_o, dec_ready_i;
    logic [38:0] dec_cw_i;
    logic [31:0] dec_data_o;
    logic [6:0]  dec_syndrome_o;
    logic [1:0]  dec_err_o;
`ifdef HSIAO_ECC_CNT_EN
    logic [15:0] cnt_corr_o, cnt_uncorr_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    hsiao_ecc_codec dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enc_valid_i    (enc_valid_i),
        .enc_ready_o    (enc_ready_o),
        .enc_data_i     (enc_data_i),
        .enc_valid_o    (enc_valid_o),
        .enc_ready_i    (enc_ready_i),
        .enc_cw_o       (enc_cw_o),
        .dec_valid_i    (dec_valid_i),
        .dec_ready_o    (dec_ready_o),
        .dec_cw_i       (dec_cw_i),
        .dec_valid_o    (dec_valid_o),
        .dec_ready_i    (dec_ready_i),
        .dec_data_o     (dec_data_o),
        .dec_syndrome_o (dec_syndrome_o),
        .dec_err_o      (dec_err_o)
`ifdef HSIAO_ECC_CNT_EN
        ,
        .cnt_corr_o     (cnt_corr_o),
        .cnt_uncorr_o   (cnt_uncorr_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic enc_one(input string tag, input logic [31:0] d, input logic [38:0] xcw);
        enc_data_i  = d;
        enc_valid_i = 1'b1;
        enc_ready_i = 1'b1;
        @(posedge clk_i); #1;
        enc_valid_i = 1'b0;
        chk({tag, ".valid"}, 64'(enc_valid_o), 64'd1);
        chk({tag, ".cw"},    64'(enc_cw_o),    64'(xcw));
    endtask

    task automatic dec_one(input string tag, input logic [38:0] cw, input logic [31:0] xd,
                           input logic [6:0] xs, input logic [1:0] xe);
        dec_cw_i    = cw;
        dec_valid_i = 1'b1;
        dec_ready_i = 1'b1;
        @(posedge clk_i); #1;
        dec_valid_i = 1'b0;
        chk({tag, ".valid"}, 64'(dec_valid_o),    64'd1);
        chk({tag, ".data"},  64'(dec_data_o),     64'(xd));
        chk({tag, ".syn"},   64'(dec_syndrome_o), 64'(xs));
        chk({tag, ".err"},   64'(dec_err_o),      64'(xe));
    endtask

    initial begin
        rst_i = 1'b1;
        enc_valid_i = 1'b0; enc_ready_i = 1'b0; enc_data_i = '0;
        dec_valid_i = 1'b0; dec_ready_i = 1'b0; dec_cw_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("rst.enc_valid", 64'(enc_valid_o), 64'd0);
        chk("rst.dec_valid", 64'(dec_valid_o), 64'd0);
        chk("rst.enc_ready", 64'(enc_ready_o), 64'd1);
        chk("rst.dec_ready", 64'(dec_ready_o), 64'd1);
        chk("rst.cw",        64'(enc_cw_o),    64'd0);
        chk("rst.err",       64'(dec_err_o),   64'd0);

        // Encode: columns 0 = 0x07, 31 = 0x62
        enc_one("enc0",  32'h0000_0000, 39'h00_0000_0000);
        enc_one("enc1",  32'h0000_0001, 39'h07_0000_0001);
        enc_one("enc31", 32'h8000_0000, 39'h62_8000_0000);
        enc_one("encX",  32'h8000_0001, 39'h65_8000_0001);
        enc_one("enc3",  32'h0000_0003, 39'h0C_0000_0003);

        // Decode
        dec_one("clean1",  39'h07_0000_0001, 32'h0000_0001, 7'h00, 2'b00);
        dec_one("dflip0",  39'h07_0000_0000, 32'h0000_0001, 7'h07, 2'b01);
        dec_one("cflip0",  39'h06_0000_0001, 32'h0000_0001, 7'h01, 2'b01);
        // Single data-bit1 flip of 0x07_00000001: syndrome is column 1 (0x0B)
        dec_one("dflip1",  39'h07_0000_0003, 32'h0000_0001, 7'h0B, 2'b01);
        // Data bits 0 and 1 both flipped: even syndrome 0x07^0x0B
        dec_one("dbl01",   39'h07_0000_0002, 32'h0000_0002, 7'h0C, 2'b10);
        dec_one("dflip31", 39'h62_0000_0000, 32'h8000_0000, 7'h62, 2'b01);
        dec_one("odd7f",   39'h7F_0000_0000, 32'h0000_0000, 7'h7F, 2'b10);
        dec_one("odd1f",   39'h1F_0000_0000, 32'h0000_0000, 7'h1F, 2'b10);
        @(posedge clk_i); #1;
        chk("drain.dec_valid", 64'(dec_valid_o), 64'd0);
        chk("drain.enc_valid", 64'(enc_valid_o), 64'd0);

        // Backpressure: word A held for 3 cycles, B offered but not taken
        dec_ready_i = 1'b0;
        dec_cw_i    = 39'h07_0000_0001;
        dec_valid_i = 1'b1;
        @(posedge clk_i); #1;
        dec_cw_i = 39'h0B_0000_0002;
        for (int k = 0; k < 3; k++) begin
            chk("hold.ready", 64'(dec_ready_o),    64'd0);
            chk("hold.valid", 64'(dec_valid_o),    64'd1);
            chk("hold.data",  64'(dec_data_o),     64'h1);
            chk("hold.syn",   64'(dec_syndrome_o), 64'h0);
            @(posedge clk_i); #1;
        end
        dec_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("b2b.B", 64'(dec_data_o), 64'h2);
        dec_cw_i = 39'h0C_0000_0003;
        @(posedge clk_i); #1;
        chk("b2b.C", 64'(dec_data_o), 64'h3);
        dec_cw_i = 39'h00_0000_0000;
        @(posedge clk_i); #1;
        chk("b2b.D", 64'(dec_data_o), 64'h0);
        chk("b2b.valid", 64'(dec_valid_o), 64'd1);
        dec_valid_i = 1'b0;
        @(posedge clk_i); #1;
        chk("b2b.end", 64'(dec_valid_o), 64'd0);

        // Reset with both channels holding words
        enc_ready_i = 1'b0; dec_ready_i = 1'b0;
        enc_data_i  = 32'h1; enc_valid_i = 1'b1;
        dec_cw_i    = 39'h07_0000_0000; dec_valid_i = 1'b1;
        @(posedge clk_i); #1;
        enc_valid_i = 1'b0; dec_valid_i = 1'b0;
        chk("pre.enc_valid", 64'(enc_valid_o), 64'd1);
        chk("pre.dec_err",   64'(dec_err_o),   64'd1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("mrst.enc_valid", 64'(enc_valid_o),    64'd0);
        chk("mrst.dec_valid", 64'(dec_valid_o),    64'd0);
        chk("mrst.enc_ready", 64'(enc_ready_o),    64'd1);
        chk("mrst.dec_ready", 64'(dec_ready_o),    64'd1);
        chk("mrst.cw",        64'(enc_cw_o),       64'd0);
        chk("mrst.data",      64'(dec_data_o),     64'd0);
        chk("mrst.syn",       64'(dec_syndrome_o), 64'd0);
        chk("mrst.err",       64'(dec_err_o),      64'd0);

`ifdef HSIAO_ECC_CNT_EN
        chk("cnt.rst_corr",   64'(cnt_corr_o),   64'd0);
        chk("cnt.rst_uncorr", 64'(cnt_uncorr_o), 64'd0);
        dec_one("cnt.u", 39'h7F_0000_0000, 32'h0, 7'h7F, 2'b10);
        chk("cnt.uncorr1", 64'(cnt_uncorr_o), 64'd1);
        dec_cw_i    = 39'h07_0000_0000;
        dec_ready_i = 1'b1;
        dec_valid_i = 1'b1;
        repeat (32'h10000) @(posedge clk_i);
        #1;
        dec_valid_i = 1'b0;
        chk("cnt.sat_corr", 64'(cnt_corr_o),   64'hFFFF);
        chk("cnt.uncorr",   64'(cnt_uncorr_o), 64'd1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("cnt.clr_corr", 64'(cnt_corr_o), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
